// File: rtl/nav_serial_pkg.sv
// Shared definitions for the navigation serial link: sync marker, receiver states
// and the CMD byte field layout used by the display decoder.
package nav_serial_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    CMD  = 2'd2,
    CHK  = 2'd3
  } rx_state_e;

  // CMD byte layout: {size, color}
  localparam int unsigned SIZE_MSB  = 7;
  localparam int unsigned SIZE_LSB  = 4;
  localparam int unsigned COLOR_MSB = 3;
  localparam int unsigned COLOR_LSB = 0;

endpackage

// File: rtl/serial_byte_shifter.sv
// LSB-first serial-to-byte shifter with a 3-bit bit counter and synchronous clear.
module serial_byte_shifter (
  input  logic       rclk,
  input  logic       reset,
  input  logic       rdata,
  input  logic       clear,
  output logic [7:0] nxt,
  output logic       byte_done
);

  logic [7:0] sr_q;
  logic [2:0] bit_cnt_q;

  // Value the shift register takes on this edge; lets the FSM decide on the 8th bit.
  assign nxt       = {rdata, sr_q[7:1]};
  assign byte_done = (bit_cnt_q == 3'd7);

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
    end else if (clear) begin
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
    end else begin
      sr_q      <= nxt;
      bit_cnt_q <= bit_cnt_q + 3'd1;
    end
  end

endmodule

// File: rtl/nav_packet_rx.sv
// Framed serial receiver: aligns to the sync byte, checks CMD against CHK = ~CMD and
// publishes good commands as a stable data register plus a toggle flag.
module nav_packet_rx
  import nav_serial_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int unsigned ERR_W     = 8
) (
  input  logic             RCLK,
  input  logic             RESET,
  input  logic             RDATA,
  output logic [7:0]       PKT_DATA,
  output logic             PKT_TOGGLE,
  output logic             LOCKED,
  output logic [ERR_W-1:0] ERR_CNT
);

  rx_state_e        state_q, state_d;
  logic [7:0]       nxt;
  logic             byte_done;
  logic             clear;
  logic             cmd_load;
  logic             pkt_good;
  logic             pkt_err;
  logic [7:0]       cmd_buf_q;
  logic [7:0]       pkt_data_q;
  logic             toggle_q;
  logic             locked_q;
  logic [ERR_W-1:0] err_cnt_q;

  serial_byte_shifter u_shifter (
    .rclk      (RCLK),
    .reset     (RESET),
    .rdata     (RDATA),
    .clear     (clear),
    .nxt       (nxt),
    .byte_done (byte_done)
  );

  always_comb begin
    state_d  = state_q;
    clear    = 1'b0;
    cmd_load = 1'b0;
    pkt_good = 1'b0;
    pkt_err  = 1'b0;
    unique case (state_q)
      HUNT: begin
        // Bit counter is free-running here; restart it on the sync match.
        if (nxt == SYNC_BYTE) begin
          state_d = CMD;
          clear   = 1'b1;
        end
      end
      SYNC: begin
        if (byte_done) begin
          if (nxt == SYNC_BYTE) begin
            state_d = CMD;
          end else begin
            pkt_err = 1'b1;
            clear   = 1'b1;
            state_d = HUNT;
          end
        end
      end
      CMD: begin
        if (byte_done) begin
          cmd_load = 1'b1;
          state_d  = CHK;
        end
      end
      CHK: begin
        if (byte_done) begin
          if (nxt == ~cmd_buf_q) begin
            pkt_good = 1'b1;
            state_d  = SYNC;
          end else begin
            pkt_err = 1'b1;
            clear   = 1'b1;
            state_d = HUNT;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge RCLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= HUNT;
      cmd_buf_q  <= 8'h00;
      pkt_data_q <= 8'hFF;
      toggle_q   <= 1'b0;
      locked_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_load) begin
        cmd_buf_q <= nxt;
      end
      if (pkt_good) begin
        pkt_data_q <= {cmd_buf_q[SIZE_MSB:SIZE_LSB], cmd_buf_q[COLOR_MSB:COLOR_LSB]};
        toggle_q   <= ~toggle_q;
        locked_q   <= 1'b1;
      end
      if (pkt_err) begin
        locked_q <= 1'b0;
        if (err_cnt_q != {ERR_W{1'b1}}) begin
          err_cnt_q <= err_cnt_q + 1'b1;
        end
      end
    end
  end

  assign PKT_DATA   = pkt_data_q;
  assign PKT_TOGGLE = toggle_q;
  assign LOCKED     = locked_q;
  assign ERR_CNT    = err_cnt_q;

endmodule
